tdm_demux4: RTL and testbench

Four-slot time-division demultiplexer: the receive end of a link that a 4:1 mux drives by stepping its select through S1S0 = 00, 01, 10, 11. The block takes the single shared data line plus a frame marker, tracks the slot position, collects one frame of four samples into a shadow buffer, and presents all four channels together on registered outputs. It sits directly after the serial link, on the consumer side of the mux datapath.

---
 rtl/tdm_demux4.sv | 120 ++++++++++++
 tb/tb_tdm_demux4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-slot TDM link. Tracks slot position from
// the frame marker, gathers four samples into a shadow buffer and presents a
// complete frame on registered channel outputs.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y00,
  output logic [WIDTH-1:0] y01,
  output logic [WIDTH-1:0] y10,
  output logic [WIDTH-1:0] y11,
  output logic             s1,
  output logic             s0,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, RECEIVE = 1'b1} state_t;

  state_t                     state, state_n;
  logic [1:0]                 slot, slot_n;
  logic [3:0][WIDTH-1:0]      shadow;
  logic                       shadow_we;
  logic [1:0]                 shadow_idx;
  logic                       load;
  logic                       err;

  // State, slot counter and shadow storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      slot   <= 2'd0;
      shadow <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      if (shadow_we) shadow[shadow_idx] <= din;
    end
  end

  // Framing decisions: only beats (din_valid=1) advance anything.
  always_comb begin
    state_n    = state;
    slot_n     = slot;
    shadow_we  = 1'b0;
    shadow_idx = slot;
    load       = 1'b0;
    err        = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            shadow_we  = 1'b1;
            shadow_idx = 2'd0;
            slot_n     = 2'd1;
            state_n    = RECEIVE;
          end
        end
        RECEIVE: begin
          if (slot != 2'd0) begin
            if (frame_sync) begin
              // Early sync: restart the frame; the partial one never loads.
              err        = 1'b1;
              shadow_we  = 1'b1;
              shadow_idx = 2'd0;
              slot_n     = 2'd1;
            end else begin
              shadow_we = 1'b1;
              slot_n    = slot + 2'd1;
              load      = (slot == 2'd3);
            end
          end else begin
            if (frame_sync) begin
              shadow_we  = 1'b1;
              shadow_idx = 2'd0;
              slot_n     = 2'd1;
            end else begin
              // Missing sync: drop the beat and go back to hunting.
              err     = 1'b1;
              slot_n  = 2'd0;
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Registered channel outputs; slot-3 sample bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y00         <= '0;
      y01         <= '0;
      y10         <= '0;
      y11         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= load;
      sync_err    <= err;
      if (load) begin
        y00 <= shadow[0];
        y01 <= shadow[1];
        y10 <= shadow[2];
        y11 <= din;
      end
    end
  end

  assign s1     = slot[1];
  assign s0     = slot[0];
  assign locked = (state == RECEIVE);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: table of per-cycle vectors with hand-derived
// expectations, queued on drive and compared after the clock edge.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  logic din, din_valid, frame_sync;
  logic y00, y01, y10, y11, s1, s0, locked, frame_valid, sync_err;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .y00(y00), .y01(y01), .y10(y10), .y11(y11),
    .s1(s1), .s0(s0), .locked(locked), .frame_valid(frame_valid),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // y packed as {y00,y01,y10,y11}
  typedef struct packed {
    logic [3:0] y;
    logic       fv;
    logic       err;
    logic [1:0] slot;
    logic       lk;
  } out_t;

  typedef struct packed {
    logic v;
    logic d;
    logic s;
    out_t e;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  out_t sb[$];

  function automatic out_t mk(input logic [3:0] y, input logic fv, input logic err,
                              input logic [1:0] slot, input logic lk);
    out_t o;
    o.y = y; o.fv = fv; o.err = err; o.slot = slot; o.lk = lk;
    return o;
  endfunction

  function automatic vec_t vv(input logic v, input logic d, input logic s, input out_t e);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = mk({y00, y01, y10, y11}, frame_valid, sync_err, {s1, s0}, locked);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got y=%b fv=%b err=%b slot=%b lk=%b, want y=%b fv=%b err=%b slot=%b lk=%b",
               name, act.y, act.fv, act.err, act.slot, act.lk,
               exp.y, exp.fv, exp.err, exp.slot, exp.lk);
    end
  endtask

  // Drive one cycle on the falling edge, compare just after the rising edge.
  task automatic step(input string name, input vec_t t);
    out_t exp;
    @(negedge clk);
    din_valid  = t.v;
    din        = t.d;
    frame_sync = t.s;
    sb.push_back(t.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      check(name, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Clean frame 1,0,0,1
    tbl.push_back(vv(1,1,1, mk(4'b0000,0,0,2'd1,1)));
    tbl.push_back(vv(1,0,0, mk(4'b0000,0,0,2'd2,1)));
    tbl.push_back(vv(1,0,0, mk(4'b0000,0,0,2'd3,1)));
    tbl.push_back(vv(1,1,0, mk(4'b1001,1,0,2'd0,1)));
    tbl.push_back(vv(0,0,0, mk(4'b1001,0,0,2'd0,1)));
    // Gapped frame 1,0,0,1; sync without valid is ignored
    tbl.push_back(vv(1,1,1, mk(4'b1001,0,0,2'd1,1)));
    tbl.push_back(vv(0,0,0, mk(4'b1001,0,0,2'd1,1)));
    tbl.push_back(vv(0,1,1, mk(4'b1001,0,0,2'd1,1)));
    tbl.push_back(vv(1,0,0, mk(4'b1001,0,0,2'd2,1)));
    tbl.push_back(vv(0,1,0, mk(4'b1001,0,0,2'd2,1)));
    tbl.push_back(vv(1,0,0, mk(4'b1001,0,0,2'd3,1)));
    tbl.push_back(vv(0,0,0, mk(4'b1001,0,0,2'd3,1)));
    tbl.push_back(vv(1,1,0, mk(4'b1001,1,0,2'd0,1)));
    // Back-to-back frame 0,1,0,0
    tbl.push_back(vv(1,0,1, mk(4'b1001,0,0,2'd1,1)));
    tbl.push_back(vv(1,1,0, mk(4'b1001,0,0,2'd2,1)));
    tbl.push_back(vv(1,0,0, mk(4'b1001,0,0,2'd3,1)));
    tbl.push_back(vv(1,0,0, mk(4'b0100,1,0,2'd0,1)));
    // Early sync: sync,1; 0; sync,0; 1; 1; 0
    tbl.push_back(vv(1,1,1, mk(4'b0100,0,0,2'd1,1)));
    tbl.push_back(vv(1,0,0, mk(4'b0100,0,0,2'd2,1)));
    tbl.push_back(vv(1,0,1, mk(4'b0100,0,1,2'd1,1)));
    tbl.push_back(vv(1,1,0, mk(4'b0100,0,0,2'd2,1)));
    tbl.push_back(vv(1,1,0, mk(4'b0100,0,0,2'd3,1)));
    tbl.push_back(vv(1,0,0, mk(4'b0110,1,0,2'd0,1)));
    // Missing sync, beat discarded in HUNT, then relock with 1,1,1,1
    tbl.push_back(vv(1,1,0, mk(4'b0110,0,1,2'd0,0)));
    tbl.push_back(vv(1,1,0, mk(4'b0110,0,0,2'd0,0)));
    tbl.push_back(vv(0,0,1, mk(4'b0110,0,0,2'd0,0)));
    tbl.push_back(vv(1,1,1, mk(4'b0110,0,0,2'd1,1)));
    tbl.push_back(vv(1,1,0, mk(4'b0110,0,0,2'd2,1)));
    tbl.push_back(vv(1,1,0, mk(4'b0110,0,0,2'd3,1)));
    tbl.push_back(vv(1,1,0, mk(4'b1111,1,0,2'd0,1)));
    tbl.push_back(vv(0,0,0, mk(4'b1111,0,0,2'd0,1)));

    // Reset held with random data on the line
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; frame_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = 1'($urandom_range(0, 1));
      din_valid = 1'($urandom_range(0, 1));
      frame_sync = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check($sformatf("reset%0d", i), mk(4'b0000,0,0,2'd0,0));
    end
    @(negedge clk);
    rst_n = 1'b1; din_valid = 1'b0; frame_sync = 1'b0;
    for (int i = 0; i < 2; i++)
      step($sformatf("idle%0d", i), vv(0,1,0, mk(4'b0000,0,0,2'd0,0)));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-frame after two beats
    step("mid_b0", vv(1,1,1, mk(4'b1111,0,0,2'd1,1)));
    step("mid_b1", vv(1,0,0, mk(4'b1111,0,0,2'd2,1)));
    #2 rst_n = 1'b0;
    #1 check("mid_async", mk(4'b0000,0,0,2'd0,0));
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b1;
    step("post_idle", vv(0,0,0, mk(4'b0000,0,0,2'd0,0)));
    step("post_b0", vv(1,0,1, mk(4'b0000,0,0,2'd1,1)));
    step("post_b1", vv(1,1,0, mk(4'b0000,0,0,2'd2,1)));
    step("post_b2", vv(1,1,0, mk(4'b0000,0,0,2'd3,1)));
    step("post_b3", vv(1,0,0, mk(4'b0110,1,0,2'd0,1)));
    step("post_hold", vv(0,0,0, mk(4'b0110,0,0,2'd0,1)));

    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
